// File: rtl/mac_result_requant_if.sv
// Bus between the MAC stage, the requant block and the output buffer writer:
// accumulator samples in, int8 results out over valid/ready, plus status.
interface mac_result_requant_if;
  logic signed [31:0] dsp_output;
  logic               dsp_valid;
  logic signed [7:0]  res_data;
  logic               res_valid;
  logic               res_ready;
  logic               vec_done;
  logic               overflow;

  modport master (
    output dsp_output, dsp_valid, res_ready,
    input  res_data, res_valid, vec_done, overflow
  );

  modport slave (
    input  dsp_output, dsp_valid, res_ready,
    output res_data, res_valid, vec_done, overflow
  );
endinterface

// File: rtl/mac_result_requant.sv
// Turns the MAC's never-clearing running accumulator into per-vector int8 results
// (difference, round, shift, saturate) queued in a show-ahead FIFO. Optional ReLU: MAC_REQUANT_RELU_EN.
module mac_result_requant #(
  parameter int VEC_LEN    = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  mac_result_requant_if.slave   bus
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

  function automatic logic signed [32:0] round_shift(input logic signed [31:0] d);
    logic signed [32:0] s;
    s = $signed({d[31], d}) + RND;
    return s >>> SHIFT;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [32:0] r);
    logic signed [7:0] q;
    if (r > 33'sd127)
      q = 8'sd127;
    else if (r < -33'sd128)
      q = -8'sd128;
    else
      q = r[7:0];
`ifdef MAC_REQUANT_RELU_EN
    if (q < 8'sd0)
      q = 8'sd0;
`endif
    return q;
  endfunction

  logic [CNT_W-1:0]   elem_cnt;
  logic signed [31:0] base;
  logic               last_elem;
  logic               take_p0;

  logic signed [31:0] dot_p1;
  logic               vld_p1;
  logic signed [7:0]  res_p2;
  logic               vld_p2;

  logic signed [7:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic               res_valid;
  logic               pop;
  logic               push_ok;
  logic               overflow;

  assign last_elem = (elem_cnt == CNT_W'(VEC_LEN - 1));
  assign take_p0   = bus.dsp_valid && last_elem;
  assign res_valid = (occ != '0);
  assign pop       = res_valid && bus.res_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok   = vld_p2 && ((occ != OCC_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      elem_cnt <= '0;
      base     <= '0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.dsp_valid) begin
        if (last_elem) begin
          elem_cnt <= '0;
          base     <= bus.dsp_output;
        end else begin
          elem_cnt <= elem_cnt + 1'b1;
        end
      end
      vld_p1 <= take_p0;
      vld_p2 <= vld_p1;
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (vld_p2 && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Stage 0 -> 1: dot product as difference from the previous vector's end value
  always_ff @(posedge clk_i) begin
    if (take_p0)
      dot_p1 <= bus.dsp_output - base;
  end

  // Stage 1 -> 2: round, shift, saturate
  always_ff @(posedge clk_i) begin
    if (vld_p1)
      res_p2 <= sat8(round_shift(dot_p1));
  end

  // Stage 2 -> FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem[wr_ptr] <= res_p2;
  end

  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_valid ? mem[rd_ptr] : 8'sd0;
  assign bus.vec_done  = vld_p2;
  assign bus.overflow  = overflow;

endmodule
